id_ex_hazard_reg: RTL
=====================

Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 64-bit five-stage pipeline. It captures decoded operands and control from the decode stage. It presents them to the execute stage: ex_rn and ex_rm feed the forwarding unit's ReadRegister1/ReadRegister2, and ex_instruction feeds its instruction input. It stalls decode and inserts bubbles on load-use hazards, squashes on taken-branch flush, and counts stall and flush events.

Parameters:
DATA_W, 64, operand/immediate width
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never a hazard source
CNT_W, 32, width of event counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_instruction  in  32  decoded instruction word
id_rn  in  REG_W  first source register
id_rm  in  REG_W  second source register (Rm, or Rt for STUR/CBZ)
id_uses_rm  in  1  instruction actually reads id_rm
id_rd  in  REG_W  destination register
id_data_a  in  DATA_W  register-file read A
id_data_b  in  DATA_W  register-file read B
id_imm  in  DATA_W  sign-extended immediate
id_ctrl  in  ctrl_t  packed control: reg_write, mem_read, mem_write, alu_src, alu_op[2:0], mem_to_reg, branch
flush  in  1  taken branch resolved in EX; squash ID and EX
stall_id  out  1  hold PC and IF/ID register this cycle
ex_valid  out  1  EX slot holds a real instruction
ex_instruction  out  32  to execute/forwarding
ex_rn, ex_rm, ex_rd  out  REG_W  register indices to execute/forwarding
ex_data_a, ex_data_b, ex_imm  out  DATA_W  operands
ex_ctrl  out  ctrl_t  control; all-zero when bubble
stall_count  out  CNT_W  load-use stall cycles since reset
flush_count  out  CNT_W  flush events since reset

Behaviour:
- Reset (rst_n low, async): all ex_* outputs 0, ex_valid 0, counters 0, FSM to RUN, stall_id 0. Release is synchronous to the next clk edge.
- Hazard term, combinational: hz = ex_valid & ex_ctrl.mem_read & (ex_rd != ZERO_REG) & id_valid & ((ex_rd == id_rn) | (id_uses_rm & ex_rd == id_rm)).
- FSM states RUN and STALL.
  - RUN with hz=1 and flush=0: stall_id=1; next edge loads a bubble (ex_valid=0, ex_ctrl=0, ex_instruction=0; other fields don't-care but driven 0); go to STALL; stall_count+1.
  - STALL: stall_id=0; the hazard cannot re-fire because EX now holds a bubble. Next edge loads the ID fields normally; return to RUN.
  - RUN with hz=0: each edge loads all id_* fields; ex_valid=id_valid; ex_ctrl=id_valid ? id_ctrl : 0.
- flush has priority over everything. On the edge with flush=1, EX loads a bubble, FSM goes to RUN, stall_id=0, and flush_count+1. The stall counter does not increment even if hz=1 on that cycle.
- Only ex_valid/ex_ctrl gate side effects. A bubble must never carry reg_write or mem_write.
- Latency: exactly one cycle from ID to EX when not stalled; a load-use pair costs exactly one bubble.
- Counters saturate at all-ones; no wrap.
- stall_id is purely combinational from current state and inputs; no registered delay.
- An id_rn or id_rm equal to ZERO_REG never causes a stall, because the ex_rd != ZERO_REG check excludes it.

Decomposition:
- Package pipe_pkg holds ctrl_t (packed struct above), the ZERO_REG constant, and the opcode constants ADDI=10'b1001000100, SUBI=10'b1101000100, STUR=11'b11111000000, LDUR=11'b11111000010, CBZ=8'b10110100. The execute and forwarding stages share this package.
- One sub-module, load_use_detect: the combinational hz term. The register and FSM stay in the top module.

Test Plan:
- Reset mid-run: drive valid ADD, then pull rst_n low between edges → ex_valid, ex_ctrl and counters read 0 immediately, without waiting for a clock.
- LDUR X1 followed by ADD X2,X1,X3 → stall_id=1 for one cycle, EX shows bubble (ex_valid=0), then ADD appears with ex_rn=1; stall_count=1.
- LDUR X31 followed by ADD reading X31 → no stall; stall_count stays 0.
- LDUR X4 followed by ADDI whose id_rm field is 4 with id_uses_rm=0 → no stall. With id_uses_rm=1 (STUR Rt=X4) → one stall.
- Load-use hazard and flush asserted on the same cycle → bubble, flush_count=1, stall_count=0, stall_id=0.
- 2^CNT_W-1 forced via a small CNT_W=3 build with 9 stalls → stall_count holds 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants
// Purpose: control bundle layout, XZR index and opcode constants shared by
//          the ID/EX register, execute stage and forwarding unit.
// Ports:   none (package).
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam int unsigned ZERO_REG = 31;

  localparam logic [9:0]  ADDI = 10'b1001000100;
  localparam logic [9:0]  SUBI = 10'b1101000100;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [7:0]  CBZ  = 8'b10110100;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard term
// Purpose: flags an ID instruction that reads the destination of a load
//          currently in EX.
// Ports:   ex_valid/ex_mem_read/ex_rd - instruction in EX
//          id_valid/id_rn/id_rm/id_uses_rm - instruction in ID
//          hz - hazard, one bubble required
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int XZR_IDX = ZERO_REG
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  output logic             hz
);

  localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

  logic rn_match;
  logic rm_match;

  assign rn_match = (ex_rd == id_rn);
  // Rm only counts when the instruction really reads it (e.g. not for ADDI).
  assign rm_match = id_uses_rm & (ex_rd == id_rm);

  // A load into XZR writes nothing, so it can never feed a consumer.
  assign hz = ex_valid & ex_mem_read & (ex_rd != XZR) & id_valid
            & (rn_match | rm_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use stall
// Purpose: registers decoded operands/control into EX, inserts one bubble
//          on a load-use hazard, squashes on flush, counts both events.
// Ports:   clk, rst_n (async active-low)
//          id_* - decode stage fields; flush - taken branch in EX
//          stall_id - hold PC and IF/ID this cycle (combinational)
//          ex_* - execute stage fields; stall_count/flush_count - events
module id_ex_hazard_reg #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = pipe_pkg::ZERO_REG,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instruction,
  input  logic [REG_W-1:0]   id_rn,
  input  logic [REG_W-1:0]   id_rm,
  input  logic               id_uses_rm,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [DATA_W-1:0]  id_data_a,
  input  logic [DATA_W-1:0]  id_data_b,
  input  logic [DATA_W-1:0]  id_imm,
  input  pipe_pkg::ctrl_t    id_ctrl,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [31:0]        ex_instruction,
  output logic [REG_W-1:0]   ex_rn,
  output logic [REG_W-1:0]   ex_rm,
  output logic [REG_W-1:0]   ex_rd,
  output logic [DATA_W-1:0]  ex_data_a,
  output logic [DATA_W-1:0]  ex_data_b,
  output logic [DATA_W-1:0]  ex_imm,
  output pipe_pkg::ctrl_t    ex_ctrl,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   hz;
  logic   stall_now;
  logic   bubble;

  load_use_detect #(
    .REG_W   (REG_W),
    .XZR_IDX (ZERO_REG)
  ) u_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .hz          (hz)
  );

  // In STALL, EX holds a bubble so hz is already 0; the state term keeps
  // the intent explicit. Flush overrides any stall request.
  assign stall_now = (state == RUN) & hz & ~flush;
  assign stall_id  = stall_now;
  assign bubble    = flush | stall_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      ex_valid       <= 1'b0;
      ex_instruction <= '0;
      ex_rn          <= '0;
      ex_rm          <= '0;
      ex_rd          <= '0;
      ex_data_a      <= '0;
      ex_data_b      <= '0;
      ex_imm         <= '0;
      ex_ctrl        <= '0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      if (bubble) begin
        // Bubble is fully zeroed so it can never carry reg_write/mem_write.
        ex_valid       <= 1'b0;
        ex_instruction <= '0;
        ex_rn          <= '0;
        ex_rm          <= '0;
        ex_rd          <= '0;
        ex_data_a      <= '0;
        ex_data_b      <= '0;
        ex_imm         <= '0;
        ex_ctrl        <= '0;
      end else begin
        ex_valid       <= id_valid;
        ex_instruction <= id_instruction;
        ex_rn          <= id_rn;
        ex_rm          <= id_rm;
        ex_rd          <= id_rd;
        ex_data_a      <= id_data_a;
        ex_data_b      <= id_data_b;
        ex_imm         <= id_imm;
        ex_ctrl        <= id_valid ? id_ctrl : '0;
      end

      state <= stall_now ? STALL : RUN;

      if (flush && flush_count != CNT_MAX) begin
        flush_count <= flush_count + CNT_ONE;
      end
      if (stall_now && stall_count != CNT_MAX) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule
